mem_access: RTL
===============

MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameter MAX_WAIT, default 15, is the number of BUSY cycles without dbus_ack before a bus timeout.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 ex_valid  input  1  EX/MEM slot holds a valid instruction.
REQ-005 ex_op  input  mem_op_t  NONE, LB, LBU, LH, LHU, LW, SB, SH, SW, LL, SC.
REQ-006 ex_addr  input  32  effective byte address.
REQ-007 ex_wdata  input  32  store data, right-justified.
REQ-008 ex_wreg  input  reg_t  destination write-back record (we, addr, data).
REQ-009 ex_hilo  input  hilo_t  HI/LO write record, passed through unchanged.
REQ-010 ll_clr  input  1  clears the LL bit (exception or ERET).
REQ-011 dbus_req/dbus_we  output  1/1  bus request and write strobe.
REQ-012 dbus_addr/dbus_be/dbus_wdata  output  32/4/32  word-aligned address, byte enables, lane-placed data.
REQ-013 dbus_ack/dbus_rdata  input  1/32  transfer-complete strobe and read word.
REQ-014 stall_req  output  1  holds EX/MEM and earlier stages.
REQ-015 mem_wreg_o/mem_hilo_o  output  reg_t/hilo_t  records to the MEM/WB register.
REQ-016 adel_o/ades_o/bus_err_o  output  1/1/1  load misalign, store misalign, and timeout pulses.

Function
REQ-017 Handle a non-memory op, or ex_valid=0, combinationally: mem_wreg_o=ex_wreg, mem_hilo_o=ex_hilo, stall_req=0, dbus_req=0.
REQ-018 Use the FSM states IDLE, BUSY and DONE.
REQ-019 IDLE, aligned memory op: assert dbus_req, assert stall_req, go to BUSY.
REQ-020 BUSY: hold all dbus_* outputs stable and keep stall_req=1.
REQ-021 BUSY with dbus_ack: latch the aligned and extended read result, clear the wait counter, go to DONE.
REQ-022 DONE: drive stall_req=0 and present the latched result on mem_wreg_o.data (SC gives 1) for exactly one cycle, then go to IDLE.
REQ-023 Latency: a memory op stalls for at least 2 cycles (request in IDLE, ack in BUSY at the earliest); each extra ack wait adds one stall cycle.
REQ-024 dbus_ack outside BUSY shall be ignored.
REQ-025 Byte order is big-endian: addr[1:0]=0 selects bits 31:24 and be=1000; a halfword at addr[1]=0 selects be=1100.
REQ-026 LB/LH shall sign-extend the selected lane and LBU/LHU shall zero-extend it to 32 bits.
REQ-027 Stores shall replicate the byte or half across all lanes; dbus_be selects the written lanes.
REQ-028 Misalignment: LH/LHU/SH with addr[0]=1, or LW/SW/LL/SC with addr[1:0]!=0, shall make no bus access, pulse adel_o (loads and LL) or ades_o (stores and SC) for one cycle, force mem_wreg_o.we=0, and not stall.
REQ-029 Timeout: after MAX_WAIT BUSY cycles without ack, drop dbus_req, pulse bus_err_o, go to DONE with mem_wreg_o.we=0.
REQ-030 LL bit: set when an LL completes; cleared when an SC completes or ll_clr=1; ll_clr takes priority over a simultaneous set.
REQ-031 SC with LL bit 0: no bus access, mem_wreg_o.data=0, we=1, no stall.
REQ-032 SC with LL bit 1: perform a word store, then return data=1.

Reset
REQ-033 On rst: state=IDLE, wait counter=0, LL bit=0, latched result=0, all dbus_* outputs=0, stall_req=0, and exception and error pulses=0.
REQ-034 rst during BUSY shall abandon the transfer with dbus_req=0 on the next cycle; a late dbus_ack shall be ignored.

Structure
REQ-035 mem_op_t, reg_t and hilo_t shall reside in project_types.
REQ-036 The FSM state enum shall be local to the module.
REQ-037 Lane extraction and sign extension shall form one combinational sub-module, mem_load_align.

Verification
REQ-038 LW at 0x100 with ack on the 3rd BUSY cycle and rdata=0xDEADBEEF -> stall_req high for 4 cycles, then mem_wreg_o.data=0xDEADBEEF for 1 cycle.
REQ-039 LB at 0x103 with rdata=0x000000F0 -> data=0xFFFFFFF0; LBU at the same address -> 0x000000F0.
REQ-040 SH at 0x102 with wdata=0x1234 -> dbus_be=0011, dbus_wdata=0x12341234, dbus_we=1.
REQ-041 LW at 0x101 -> adel_o pulse, dbus_req stays 0, mem_wreg_o.we=0, no stall.
REQ-042 LL at 0x200 then SC at 0x200 -> store issued and data=1; a second SC -> no store and data=0; LL with simultaneous ll_clr then SC -> data=0.
REQ-043 With dbus_ack never asserted -> bus_err_o after 15 BUSY cycles; rst in BUSY -> dbus_req=0 next cycle.

Source files
------------

// File: rtl/project_types.sv
// Shared pipeline types for the memory stage: op codes and write-back records.
// Latency: n/a (types and pure helper functions only).
// Backpressure: n/a.
package project_types;

    typedef enum logic [3:0] {
        MEM_NONE,
        MEM_LB,
        MEM_LBU,
        MEM_LH,
        MEM_LHU,
        MEM_LW,
        MEM_SB,
        MEM_SH,
        MEM_SW,
        MEM_LL,
        MEM_SC
    } mem_op_t;

    // General-purpose register write-back record.
    typedef struct packed {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
    } reg_t;

    // HI/LO write record; the memory stage only forwards it.
    typedef struct packed {
        logic        we;
        logic [31:0] hi;
        logic [31:0] lo;
    } hilo_t;

    function automatic logic op_is_load(input mem_op_t op);
        return op inside {MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW, MEM_LL};
    endfunction

    // Halfword ops need an even address, word ops (including LL/SC) a
    // word-aligned one; byte ops can never be misaligned.
    function automatic logic op_misaligned(input mem_op_t op, input logic [1:0] off);
        case (op)
            MEM_LH, MEM_LHU, MEM_SH:         return off[0];
            MEM_LW, MEM_SW, MEM_LL, MEM_SC:  return off != 2'b00;
            default:                         return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Extracts the addressed byte/half of a big-endian bus word and extends it to 32 bits.
// Latency: combinational.
// Backpressure: none.
// Ports: op (load kind), byte_off (addr[1:0]), rdata (bus word) -> data (extended result).
module mem_load_align
    import project_types::*;
(
    input  mem_op_t     op,
    input  logic [1:0]  byte_off,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        // Big-endian: offset 0 is the most significant byte of the word.
        case (byte_off)
            2'd0:    byte_lane = rdata[31:24];
            2'd1:    byte_lane = rdata[23:16];
            2'd2:    byte_lane = rdata[15:8];
            default: byte_lane = rdata[7:0];
        endcase
        half_lane = byte_off[1] ? rdata[15:0] : rdata[31:16];

        case (op)
            MEM_LB:  data = {{24{byte_lane[7]}}, byte_lane};
            MEM_LBU: data = {24'h0, byte_lane};
            MEM_LH:  data = {{16{half_lane[15]}}, half_lane};
            MEM_LHU: data = {16'h0, half_lane};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// MEM stage: drives the data bus for loads/stores/LL/SC, aligns read data, tracks the LL bit.
// Latency: non-memory ops and faulting ops pass through combinationally; bus ops stall >= 2 cycles.
// Backpressure: stall_req holds upstream until dbus_ack or MAX_WAIT BUSY cycles elapse.
// Ports: ex_* (EX/MEM slot), ll_clr, dbus_* (data bus), stall_req, mem_wreg_o/mem_hilo_o
//        (to MEM/WB), adel_o/ades_o (misalign), bus_err_o (bus timeout).
module mem_access
    import project_types::*;
#(
    parameter int MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  mem_op_t     ex_op,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    input  reg_t        ex_wreg,
    input  hilo_t       ex_hilo,
    input  logic        ll_clr,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [3:0]  dbus_be,
    output logic [31:0] dbus_wdata,
    input  logic        dbus_ack,
    input  logic [31:0] dbus_rdata,
    output logic        stall_req,
    output reg_t        mem_wreg_o,
    output hilo_t       mem_hilo_o,
    output logic        adel_o,
    output logic        ades_o,
    output logic        bus_err_o
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam int            CW        = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);

    state_t        state, state_nxt;
    logic [CW-1:0] wait_cnt, wait_cnt_nxt;
    logic          ll_bit, ll_bit_nxt;
    logic [31:0]   result_q, result_nxt;
    logic          timeout_q, timeout_nxt;

    // Bus request captured at issue so BUSY outputs stay stable.
    logic          bus_we_q;
    logic [31:0]   bus_addr_q;
    logic [3:0]    bus_be_q;
    logic [31:0]   bus_wdata_q;

    logic          is_mem, is_load, misalign, sc_fail;
    logic [3:0]    req_be;
    logic [31:0]   req_wdata;
    logic [31:0]   load_data;

    mem_load_align u_align (
        .op       (ex_op),
        .byte_off (ex_addr[1:0]),
        .rdata    (dbus_rdata),
        .data     (load_data)
    );

    // Request decode: byte/half stores replicate across every lane and rely on
    // the byte enables to pick the written lanes.
    always_comb begin
        is_mem   = ex_valid && (ex_op != MEM_NONE);
        is_load  = op_is_load(ex_op);
        misalign = op_misaligned(ex_op, ex_addr[1:0]);
        sc_fail  = (ex_op == MEM_SC) && !ll_bit;
        case (ex_op)
            MEM_LB, MEM_LBU, MEM_SB: begin
                req_be    = 4'b1000 >> ex_addr[1:0];
                req_wdata = {4{ex_wdata[7:0]}};
            end
            MEM_LH, MEM_LHU, MEM_SH: begin
                req_be    = ex_addr[1] ? 4'b0011 : 4'b1100;
                req_wdata = {2{ex_wdata[15:0]}};
            end
            default: begin
                req_be    = 4'b1111;
                req_wdata = ex_wdata;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            ll_bit      <= 1'b0;
            result_q    <= '0;
            timeout_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_be_q    <= '0;
            bus_wdata_q <= '0;
        end else begin
            state     <= state_nxt;
            wait_cnt  <= wait_cnt_nxt;
            ll_bit    <= ll_bit_nxt;
            result_q  <= result_nxt;
            timeout_q <= timeout_nxt;
            if (state == IDLE && state_nxt == BUSY) begin
                bus_we_q    <= !is_load;
                bus_addr_q  <= {ex_addr[31:2], 2'b00};
                bus_be_q    <= req_be;
                bus_wdata_q <= req_wdata;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        ll_bit_nxt   = ll_bit;
        result_nxt   = result_q;
        timeout_nxt  = timeout_q;
        dbus_req     = 1'b0;
        dbus_we      = 1'b0;
        dbus_addr    = '0;
        dbus_be      = '0;
        dbus_wdata   = '0;
        stall_req    = 1'b0;
        mem_wreg_o   = ex_wreg;
        mem_hilo_o   = ex_hilo;
        adel_o       = 1'b0;
        ades_o       = 1'b0;
        bus_err_o    = 1'b0;

        case (state)
            IDLE: begin
                if (is_mem) begin
                    if (misalign) begin
                        adel_o        = is_load;
                        ades_o        = !is_load;
                        mem_wreg_o.we = 1'b0;
                    end else if (sc_fail) begin
                        mem_wreg_o.we   = 1'b1;
                        mem_wreg_o.data = '0;
                    end else begin
                        dbus_req      = 1'b1;
                        dbus_we       = !is_load;
                        dbus_addr     = {ex_addr[31:2], 2'b00};
                        dbus_be       = req_be;
                        dbus_wdata    = req_wdata;
                        stall_req     = 1'b1;
                        mem_wreg_o.we = 1'b0;
                        wait_cnt_nxt  = '0;
                        timeout_nxt   = 1'b0;
                        state_nxt     = BUSY;
                    end
                end
            end
            BUSY: begin
                dbus_req      = 1'b1;
                dbus_we       = bus_we_q;
                dbus_addr     = bus_addr_q;
                dbus_be       = bus_be_q;
                dbus_wdata    = bus_wdata_q;
                stall_req     = 1'b1;
                mem_wreg_o.we = 1'b0;
                if (dbus_ack) begin
                    if (ex_op == MEM_SC)
                        result_nxt = 32'd1;
                    else if (is_load)
                        result_nxt = load_data;
                    else
                        result_nxt = ex_wreg.data;
                    if (ex_op == MEM_LL) ll_bit_nxt = 1'b1;
                    if (ex_op == MEM_SC) ll_bit_nxt = 1'b0;
                    wait_cnt_nxt = '0;
                    state_nxt    = DONE;
                end else if (wait_cnt == WAIT_LAST) begin
                    timeout_nxt  = 1'b1;
                    wait_cnt_nxt = '0;
                    state_nxt    = DONE;
                end else begin
                    wait_cnt_nxt = wait_cnt + CW'(1);
                end
            end
            DONE: begin
                mem_wreg_o.data = result_q;
                if (timeout_q)
                    mem_wreg_o.we = 1'b0;
                else if (ex_op == MEM_SC)
                    mem_wreg_o.we = 1'b1;
                bus_err_o = timeout_q;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        // An exception/ERET in the same cycle as an LL completing wins.
        if (ll_clr) ll_bit_nxt = 1'b0;

        // Keep the bus and pipeline controls quiet while reset is applied, so a
        // transfer in flight is abandoned immediately.
        if (rst) begin
            dbus_req   = 1'b0;
            dbus_we    = 1'b0;
            dbus_addr  = '0;
            dbus_be    = '0;
            dbus_wdata = '0;
            stall_req  = 1'b0;
            adel_o     = 1'b0;
            ades_o     = 1'b0;
            bus_err_o  = 1'b0;
        end
    end

endmodule
